// File: rtl/tp84_snd_pkg.sv
// Shared types and constants for the TP84 sound output filter.
// The filter coefficients are Q0.16 fractions; the state enum is also exported for debug.
package tp84_snd_pkg;

    localparam int SMP_W = 16;
    localparam int ACC_W = 18;

    localparam logic [15:0] K_LIGHT  = 16'd30566;
    localparam logic [15:0] K_MEDIUM = 16'd17667;
    localparam logic [15:0] K_HEAVY  = 16'd9530;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        LIGHT  = 2'd1,
        MEDIUM = 2'd2,
        HEAVY  = 2'd3
    } vol_sel_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIFF = 3'd1,
        MUL  = 3'd2,
        ACC  = 3'd3,
        OUT  = 3'd4
    } fsm_state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd32768;

    function automatic logic [15:0] coef(input vol_sel_e v);
        case (v)
            LIGHT:   return K_LIGHT;
            MEDIUM:  return K_MEDIUM;
            HEAVY:   return K_HEAVY;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic signed [SMP_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return 16'sh7fff;
        else if (v < SAT_MIN) return 16'sh8000;
        else return v[SMP_W-1:0];
    endfunction

endpackage

// File: rtl/tp84_seqmul.sv
// 17x16 signed-by-unsigned serial multiplier, LSB-first shift-add.
// start loads operands; sixteen steps later done pulses for one cycle with product valid.
module tp84_seqmul
    import tp84_snd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [16:0] a,
    input  logic        [15:0] b,
    output logic               done,
    output logic signed [32:0] product
);

    logic signed [32:0] mcand;
    logic signed [32:0] acc;
    logic        [15:0] mplier;
    logic        [3:0]  step_cnt;
    logic               busy;

    // Handshake: start is a single-cycle request, ignored while busy is not
    // checked because the controller only raises it from DIFF; done is a
    // one-cycle pulse and product holds until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand    <= {{16{a[16]}}, a};
                mplier   <= b;
                acc      <= '0;
                step_cnt <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand    <= mcand <<< 1;
                mplier   <= mplier >> 1;
                step_cnt <= step_cnt + 4'd1;
                if (step_cnt == 4'd15) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/tp84_snd_out_filter.sv
// TP84 audio output stage: 48 kHz first-order low-pass, mute, saturation, strobed output.
// Optional TP84_SOFTMUTE_EN replaces the hard mute with a 256-step gain ramp.
module tp84_snd_out_filter
    import tp84_snd_pkg::*;
#(
    parameter int CEN_DIV = 1024
)
(
    input  logic                    clk_49m,
    input  logic                    reset,
    input  logic signed [SMP_W-1:0] sound_in,
    input  logic        [1:0]       vol_sel,
    input  logic                    mute,
    output logic signed [SMP_W-1:0] sound_out,
    output logic                    sample_strobe,
    output logic        [2:0]       dbg_state
);

    localparam int CNT_W = $clog2(CEN_DIV);

    if (CEN_DIV < 32) begin : g_cen_div_check
        $error("CEN_DIV must be at least 32");
    end

    fsm_state_e state, next_state;
    logic [CNT_W-1:0] cnt;
    logic tick, capture, mul_start, acc_en, out_en, mul_done;
    logic signed [SMP_W-1:0] x, y, out_val;
    vol_sel_e vsel;
    logic m;
    logic signed [16:0] d, step;
    logic signed [32:0] product;
    logic signed [ACC_W-1:0] sum;
    logic [15:0] k;

    assign tick = (cnt == CNT_W'(CEN_DIV - 1));

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick) next_state = DIFF;
            DIFF:    next_state = MUL;
            MUL:     if (mul_done) next_state = ACC;
            ACC:     next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        capture   = (state == IDLE) && tick;
        mul_start = (state == DIFF);
        acc_en    = (state == ACC);
        out_en    = (state == OUT);
    end

    assign dbg_state = state;

    assign d    = 17'(x) - 17'(y);
    assign k    = coef(vsel);
    assign step = product[32:16];
    assign sum  = ACC_W'(y) + ACC_W'(step);

    tp84_seqmul u_mul (
        .clk     (clk_49m),
        .rst     (reset),
        .start   (mul_start),
        .a       (d),
        .b       (k),
        .done    (mul_done),
        .product (product)
    );

`ifdef TP84_SOFTMUTE_EN
    logic [8:0] g;
    logic signed [23:0] scaled;

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            g <= 9'd256;
        end else if (acc_en) begin
            if (m) g <= (g == 9'd0)   ? 9'd0   : g - 9'd1;
            else   g <= (g == 9'd256) ? 9'd256 : g + 9'd1;
        end
    end

    // y * g never exceeds 24 signed bits because g tops out at 256
    assign scaled  = 24'(y) * 24'($signed({1'b0, g}));
    assign out_val = SMP_W'(scaled >>> 8);
`else
    assign out_val = m ? '0 : y;
`endif

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            x             <= '0;
            y             <= '0;
            vsel          <= BYPASS;
            m             <= 1'b0;
            sound_out     <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            if (capture) begin
                x    <= sound_in;
                vsel <= vol_sel_e'(vol_sel);
                m    <= mute;
            end
            // Bypass still walks through the multiplier so timing is identical
            if (acc_en) y <= (vsel == BYPASS) ? x : sat16(sum);
            if (out_en) begin
                sound_out     <= out_val;
                sample_strobe <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tp84_snd_out_filter.sv
// Directed bench for tp84_snd_out_filter with a short sample period (CEN_DIV=64).
// Build with TP84_SOFTMUTE_EN to exercise the gain-ramp mute instead of the hard mute.
module tb_tp84_snd_out_filter;
    import tp84_snd_pkg::*;

    localparam int CEN_DIV = 64;

    logic clk_49m = 1'b0;
    logic reset = 1'b1;
    logic signed [15:0] sound_in = '0;
    logic [1:0] vol_sel = '0;
    logic mute = 1'b0;
    logic signed [15:0] sound_out;
    logic sample_strobe;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic signed [15:0] exp_q[$];

    typedef struct {
        string name;
        int    sin;
        int    vs;
        int    exp;
    } vec_t;

    vec_t vecs[13];

    tp84_snd_out_filter #(.CEN_DIV(CEN_DIV)) dut (
        .clk_49m       (clk_49m),
        .reset         (reset),
        .sound_in      (sound_in),
        .vol_sel       (vol_sel),
        .mute          (mute),
        .sound_out     (sound_out),
        .sample_strobe (sample_strobe),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk_49m = ~clk_49m;

    // driver tasks
    task automatic drive(input int sin, input int vs, input bit m);
        sound_in = 16'(sin);
        vol_sel  = 2'(vs);
        mute     = m;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_strobe(output int edges, output bit ok);
        edges = 0;
        ok = 1'b0;
        while (!ok && edges < 4 * CEN_DIV) begin
            @(negedge clk_49m);
            edges++;
            ok = sample_strobe;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL strobe_timeout: no strobe in %0d cycles, expected one", 4 * CEN_DIV);
        end
    endtask

    // scoreboard
    task automatic expect_sample(input string name, input int exp, output int edges);
        bit ok;
        logic signed [15:0] e;
        exp_q.push_back(16'(exp));
        wait_strobe(edges, ok);
        e = exp_q.pop_front();
        if (ok) check(name, int'(sound_out), int'(e));
    endtask

    initial begin
        int edges;
        int prev;
        int extra;
        int strobes;
        longint ym;

        vecs[0]  = '{"bypass_neg",      -20000, 0, -20000};
        vecs[1]  = '{"bypass_pos",       12345, 0,  12345};
        vecs[2]  = '{"bypass_max",       32767, 0,  32767};
        vecs[3]  = '{"bypass_min",      -32768, 0, -32768};
        vecs[4]  = '{"light_step",           0, 1, -17485};
        vecs[5]  = '{"medium_step",          0, 2, -12772};
        vecs[6]  = '{"light_big_d",      32767, 1,   8467};
        vecs[7]  = '{"bypass_zero",          0, 0,      0};
        vecs[8]  = '{"heavy_neg_floor", -10000, 3,  -1455};
        vecs[9]  = '{"bypass_zero2",         0, 0,      0};
        vecs[10] = '{"bypass_max2",      32767, 0,  32767};
        vecs[11] = '{"light_d_min",     -32768, 1,   2201};
        vecs[12] = '{"bypass_zero3",         0, 0,      0};

        drive(vecs[0].sin, vecs[0].vs, 1'b0);
        repeat (4) @(negedge clk_49m);
        check("reset_sound_out", int'(sound_out), 0);
        check("reset_strobe", int'(sample_strobe), 0);
        check("reset_state", int'(dbg_state), int'(IDLE));
        reset = 1'b0;

        // table: each vector is driven right after the previous strobe
        for (int i = 0; i < 13; i++) begin
            if (i > 0) drive(vecs[i].sin, vecs[i].vs, 1'b0);
            expect_sample(vecs[i].name, vecs[i].exp, edges);
            if (i == 0) check("first_strobe_cycles", edges - 1, CEN_DIV + 19);
        end

        // heavy filter step response from y=0
        drive(10000, 3, 1'b0);
        ym = 0;
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            ym = ym + (((64'sd10000 - ym) * 64'sd9530) >>> 16);
            expect_sample("heavy_ramp", int'(ym), edges);
            if (i == 0) check("heavy_first", int'(sound_out), 1454);
            check("heavy_monotonic", int'(int'(sound_out) >= prev), 1);
            prev = int'(sound_out);
        end
        check("heavy_settled", int'(sound_out), 9994);

        // strobe width and spacing
        drive(16384, 0, 1'b0);
        expect_sample("spacing_sync", 16384, edges);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            expect_sample("spacing_value", 16384, edges);
            check("strobe_spacing", edges + extra, CEN_DIV);
            @(negedge clk_49m);
            check("strobe_width", int'(sample_strobe), 0);
            extra = 1;
        end

`ifdef TP84_SOFTMUTE_EN
        drive(16384, 0, 1'b1);
        for (int i = 1; i <= 257; i++)
            expect_sample("softmute_down", (i >= 256) ? 0 : 64 * (256 - i), edges);
        drive(16384, 0, 1'b0);
        for (int i = 1; i <= 257; i++)
            expect_sample("softmute_up", (i >= 256) ? 16384 : 64 * i, edges);
`else
        drive(16384, 0, 1'b1);
        expect_sample("hardmute_on", 0, edges);
        drive(0, 3, 1'b1);
        expect_sample("hardmute_filter_runs", 0, edges);
        drive(0, 3, 1'b0);
        expect_sample("hardmute_release_y", 11965, edges);
        drive(16384, 0, 1'b1);
        expect_sample("hardmute_on2", 0, edges);
        drive(16384, 0, 1'b0);
        expect_sample("hardmute_off", 16384, edges);
`endif

        // reset ten cycles into MUL, then rebuild from y=0
        drive(8000, 0, 1'b0);
        expect_sample("pre_reset", 8000, edges);
        drive(1000, 1, 1'b0);
        repeat (CEN_DIV - 9) @(negedge clk_49m);
        check("abort_in_mul", int'(dbg_state), int'(MUL));
        reset = 1'b1;
        #1;
        check("abort_sound_out", int'(sound_out), 0);
        check("abort_strobe", int'(sample_strobe), 0);
        check("abort_state", int'(dbg_state), int'(IDLE));
        strobes = 0;
        repeat (40) begin
            @(negedge clk_49m);
            if (sample_strobe) strobes++;
        end
        check("aborted_no_strobe", strobes, 0);
        reset = 1'b0;
        expect_sample("rebuilt_from_zero", 466, edges);
        check("post_reset_strobe_cycles", edges - 1, CEN_DIV + 19);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
